// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding, frame
//                constants and the default bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame shape: 8N1
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    // Default number of clk cycles per serial bit
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Receiver state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    // Width of a counter that must hold clks_per_bit-1 without wrapping
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Multi-flop synchronizer for asynchronous inputs. Generic in
//                width so the same block can condition the receive line as
//                well as transmit-side control inputs. Every flop resets to
//                RESET_VALUE so an idle-high line does not produce a false
//                edge out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_stage[s] <= {WIDTH{RESET_VALUE}};
            end
        end else begin
            r_stage[0] <= i_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. The serial line is synchronized, a
//                falling edge starts a frame, the start bit is re-checked at
//                mid-bit, then data and stop bits are sampled one bit period
//                apart. A completed byte is held with a ready flag until the
//                consumer acknowledges it; framing and overrun conditions are
//                reported through sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 read_data,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 framing_error,
    output logic                 overrun_error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                CNT_W      = cnt_width(CLKS_PER_BIT);
    localparam int                IDX_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  C_CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                  w_rxs;          // synchronized serial line
    logic                  r_rxs_d;        // previous synchronized value
    logic                  w_fall;         // 1->0 transition on w_rxs

    uart_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;          // cycles within current bit
    logic [IDX_W-1:0]      r_bit_idx;      // data bit being sampled
    logic [DATA_BITS-1:0]  r_shift;        // byte being assembled
    logic                  r_busy;

    logic [DATA_BITS-1:0]  r_data;
    logic                  r_ready;
    logic                  r_ferr;
    logic                  r_ovr;

    logic                  w_stop_sample;  // stop-bit sample point
    logic                  w_complete;     // good stop bit: byte finished
    logic                  w_frame_err;    // stop bit sampled low
    logic                  w_accept;       // completed byte is stored
    logic                  w_overrun;      // completed byte is dropped
    logic                  w_err_evt;      // any new error this cycle

    // ------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------
    uart_sync #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (rx_in),
        .o_sync  (w_rxs)
    );

    assign w_fall = r_rxs_d & ~w_rxs;

    // ------------------------------------------------------------------------
    // Completion / error decode (only meaningful at the stop-bit sample)
    // ------------------------------------------------------------------------
    assign w_stop_sample = (r_state == ST_STOP) && (r_cnt == C_CNT_LAST);
    assign w_complete    = w_stop_sample &  w_rxs;
    assign w_frame_err   = w_stop_sample & ~w_rxs;

    // A held byte is only replaced when the consumer reads it in the same cycle
    assign w_accept      = w_complete & (~r_ready | read_data);
    assign w_overrun     = w_complete &   r_ready & ~read_data;
    assign w_err_evt     = w_frame_err | w_overrun;

    // ------------------------------------------------------------------------
    // Receive state machine: bit timing, sampling and busy indication
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rxs_d <= w_rxs;

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the start bit at its midpoint to reject glitches
                ST_START: begin
                    if (r_cnt == C_CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end

                // Sample each data bit one full period after the previous one
                ST_DATA: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == C_IDX_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + C_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end

                // Good stop bit returns to idle; a low stop bit waits for
                // the line to recover so a break is not read as a new frame
                ST_STOP: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Consumer handshake: held byte, ready flag and sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= r_shift;
            end

            // Completion always leaves a byte held (new or old)
            if (w_complete) begin
                r_ready <= 1'b1;
            end else if (read_data) begin
                r_ready <= 1'b0;
            end

            // Flags clear on a read only when no new error arrives with it
            if (w_frame_err) begin
                r_ferr <= 1'b1;
            end else if (read_data && !w_err_evt) begin
                r_ferr <= 1'b0;
            end

            if (w_overrun) begin
                r_ovr <= 1'b1;
            end else if (read_data && !w_err_evt) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data          = r_data;
    assign rx_ready      = r_ready;
    assign rx_busy       = r_busy;
    assign framing_error = r_ferr;
    assign overrun_error = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed bench for uart_rx. Stimulus pushes each byte that
//                should be delivered into a scoreboard queue; a monitor pops
//                and compares whenever the receiver presents a new byte.
//                Flag and state conditions are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB       = 16;
    localparam int FRAME_CYC = 10 * CPB;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_in     = 1'b1;
    logic       read_data = 1'b0;
    logic [7:0] data;
    logic       rx_ready;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun_error;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       oe;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       mon_prev_rdy  = 1'b0;
    logic [7:0] mon_prev_data = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .read_data     (read_data),
        .data          (data),
        .rx_ready      (rx_ready),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic oe);
        return {d, fe, oe};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        read_data = 1'b1;
        @(negedge clk);
        read_data = 1'b0;
    endtask

    // One 8N1 frame driven on negedges; optional read pulse / reset at a
    // given cycle offset from the start bit (-1 = none)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int rd_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            rx_in     = bits[i / CPB];
            read_data = (i == rd_at);
            if (rst_at >= 0 && i == rst_at)     reset = 1'b1;
            if (rst_at >= 0 && i == rst_at + 3) reset = 1'b0;
        end
    endtask

    // Monitor: a byte is presented when ready rises or the held byte changes
    always @(negedge clk) begin
        if (reset) begin
            mon_prev_rdy  = 1'b0;
            mon_prev_data = data;
        end else begin
            if (rx_ready && (!mon_prev_rdy || data !== mon_prev_data)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got byte 0x%02h, expected no byte (t=%0t)", data, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", 32'(data), 32'(mon_e.d));
                    check("sb_ferr", 32'(framing_error), 32'(mon_e.fe));
                    check("sb_oerr", 32'(overrun_error), 32'(mon_e.oe));
                end
            end
            mon_prev_rdy  = rx_ready;
            mon_prev_data = data;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_data",  32'(data),          32'h00);
        check("rst_ready", 32'(rx_ready),      32'd0);
        check("rst_busy",  32'(rx_busy),       32'd0);
        check("rst_ferr",  32'(framing_error), 32'd0);
        check("rst_oerr",  32'(overrun_error), 32'd0);

        // Basic byte 0xA5 then acknowledge
        sb_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(8);
        check("a5_ready", 32'(rx_ready), 32'd1);
        check("a5_busy",  32'(rx_busy),  32'd0);
        pulse_read();
        check("a5_read_clears", 32'(rx_ready), 32'd0);
        check("a5_data_kept",   32'(data),     32'hA5);

        // 4-cycle low glitch on idle line
        @(negedge clk);
        rx_in = 1'b0;
        idle(4);
        check("glitch_busy_in_start", 32'(rx_busy), 32'd1);
        rx_in = 1'b1;
        idle(30);
        check("glitch_busy", 32'(rx_busy),       32'd0);
        check("glitch_ready",32'(rx_ready),      32'd0);
        check("glitch_data", 32'(data),          32'hA5);
        check("glitch_ferr", 32'(framing_error), 32'd0);
        check("glitch_oerr", 32'(overrun_error), 32'd0);

        // 0x3C with a low stop bit, line held low afterwards
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(40);
        check("fe_set",       32'(framing_error), 32'd1);
        check("fe_ready",     32'(rx_ready),      32'd0);
        check("fe_wait_high", 32'(rx_busy),       32'd1);
        check("fe_data",      32'(data),          32'hA5);
        rx_in = 1'b1;
        idle(6);
        check("fe_idle_after_high", 32'(rx_busy),       32'd0);
        check("fe_sticky",          32'(framing_error), 32'd1);
        pulse_read();
        check("fe_cleared", 32'(framing_error), 32'd0);

        // Overrun: 0x11 then 0x22 without reading
        sb_q.push_back(mk(8'h11, 1'b0, 1'b0));
        send_frame(8'h11, 1'b1, -1, -1);
        idle(16);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(8);
        check("ovr_set",   32'(overrun_error), 32'd1);
        check("ovr_data",  32'(data),          32'h11);
        check("ovr_ready", 32'(rx_ready),      32'd1);
        pulse_read();
        check("ovr_cleared",     32'(overrun_error), 32'd0);
        check("ovr_ready_clear", 32'(rx_ready),      32'd0);

        // Same sequence, read pulsed in the completion cycle of 0x22
        sb_q.push_back(mk(8'h11, 1'b0, 1'b0));
        send_frame(8'h11, 1'b1, -1, -1);
        idle(16);
        sb_q.push_back(mk(8'h22, 1'b0, 1'b0));
        send_frame(8'h22, 1'b1, 154, -1);
        idle(8);
        check("rdsame_ready", 32'(rx_ready),      32'd1);
        check("rdsame_oerr",  32'(overrun_error), 32'd0);
        check("rdsame_data",  32'(data),          32'h22);
        pulse_read();

        // Reset during data bit 4 of 0xFF, then a full 0x5A
        send_frame(8'hFF, 1'b1, -1, 88);
        idle(8);
        check("midrst_data",  32'(data),          32'h00);
        check("midrst_ready", 32'(rx_ready),      32'd0);
        check("midrst_busy",  32'(rx_busy),       32'd0);
        check("midrst_ferr",  32'(framing_error), 32'd0);
        sb_q.push_back(mk(8'h5A, 1'b0, 1'b0));
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(8);
        check("resume_ready", 32'(rx_ready), 32'd1);
        pulse_read();

        // Back-to-back frames, each read shortly after completion
        sb_q.push_back(mk(8'h00, 1'b0, 1'b0));
        send_frame(8'h00, 1'b1, 157, -1);
        sb_q.push_back(mk(8'hFF, 1'b0, 1'b0));
        send_frame(8'hFF, 1'b1, 157, -1);
        sb_q.push_back(mk(8'h81, 1'b0, 1'b0));
        send_frame(8'h81, 1'b1, 157, -1);
        read_data = 1'b0;
        idle(8);
        check("b2b_ready", 32'(rx_ready), 32'd0);
        check("b2b_busy",  32'(rx_busy),  32'd0);
        check("b2b_data",  32'(data),     32'h81);

        // Every expected byte must have been presented
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
